// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Contents: digit count, segment/nibble types, blanking constants and
// the scan FSM state enum.
package display_pkg;
  localparam int DIGITS = 4;
  localparam int IDX_W  = $clog2(DIGITS);

  typedef logic [6:0] seg_t;     // active-low, bit0=a .. bit6=g
  typedef logic [3:0] nibble_t;

  localparam seg_t              SEG_BLANK = 7'h7F;
  localparam logic [DIGITS-1:0] AN_OFF    = 4'hF;

  typedef enum logic {BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern (0-9, A, b, C, d, E, F).
// Ports:
//   nib  in   hex digit
//   seg  out  segments, active-low, bit0=a .. bit6=g
module seg7_hex_decode
  import display_pkg::*;
(
  input  nibble_t nib,
  output seg_t    seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. One digit is enabled per slot after a short all-off dead time;
// new frames are double-buffered and swapped in only at frame boundaries.
// Build option: define DISP_LZ_BLANK_EN for leading-zero blanking.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_valid     frame offered on in_digits (nibble k = digit k, k=0 rightmost)
//   in_ready     pending buffer empty; accept = in_valid && in_ready
//   an_n         digit enables, active-low
//   seg_n        segments, active-low
//   frame_done   one-cycle pulse after digit 3's slot ends
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DEAD_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [4*DIGITS-1:0] in_digits,
  output logic                in_ready,
  output logic [DIGITS-1:0]   an_n,
  output seg_t                seg_n,
  output logic                frame_done
);
  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  scan_state_t             state, state_nxt;
  logic [DIGITS-1:0][3:0]  active, pending;
  logic                    pending_full;
  logic                    tick, boundary, blank_digit;
  nibble_t                 cur_nib;
  seg_t                    dec_seg, seg_nxt;
  logic [DIGITS-1:0]       an_nxt;

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == IDX_W'(DIGITS - 1));
  assign in_ready = !pending_full;
  assign cur_nib  = active[idx];

  seg7_hex_decode u_dec (.nib(cur_nib), .seg(dec_seg));

`ifdef DISP_LZ_BLANK_EN
  // lz[k]: digit k and every digit above it are zero
  logic [DIGITS-1:0] lz;
  logic              lz_acc;
  always_comb begin
    lz     = '0;
    lz_acc = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_acc = lz_acc && (active[k] == 4'h0);
      lz[k]  = lz_acc;
    end
  end
  assign blank_digit = lz[idx] && (idx != '0);
`else
  assign blank_digit = 1'b0;
`endif

  // prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BLANK;
    else        state <= state_nxt;
  end

  // Outputs are registered from the next state. Entering or staying in SHOW
  // never coincides with a tick, so idx and active are already stable and
  // the decoder can sit directly on active[idx].
  always_comb begin
    state_nxt = state;
    an_nxt    = AN_OFF;
    seg_nxt   = SEG_BLANK;
    case (state)
      BLANK: if (cnt == DEAD_LAST) state_nxt = SHOW;
      SHOW:  ;
      default: state_nxt = BLANK;
    endcase
    if (tick) state_nxt = BLANK;
    if (state_nxt == SHOW) begin
      an_nxt  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx);
      seg_nxt = blank_digit ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= AN_OFF;
      seg_n      <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an_n       <= an_nxt;
      seg_n      <= seg_nxt;
      frame_done <= boundary;
    end
  end

  // Double buffer. Accept and transfer are exclusive: accept needs
  // pending empty, transfer needs it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      active       <= '0;
      pending_full <= 1'b0;
    end else if (in_valid && in_ready) begin
      pending      <= in_digits;
      pending_full <= 1'b1;
    end else if (boundary && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end
  end
endmodule
